// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the data-memory access controller.
// Pages are 4K words of 16 bits, selected by the top nibble of the word address.
package mem_ctrl_pkg;

    localparam int PAGE_ADDR_W = 12;
    localparam int PAGE_IDX_W  = 4;
    localparam int DATA_W      = 16;
    localparam int MAX_PAGES   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RDWAIT,
        ST_RESP
    } state_t;

    function automatic logic page_valid(input logic [PAGE_IDX_W-1:0] idx, input int num_pages);
        return int'(idx) < num_pages;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_page_rd_mux.sv
// Selects one page's asynchronous read data by page index.
// An index with no attached page reads as zero.
module page_rd_mux
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_PAGES = 4
) (
    input  logic [DATA_W*NUM_PAGES-1:0] data_out_page,
    input  logic [PAGE_IDX_W-1:0]       page_idx,
    output logic [DATA_W-1:0]           rd_data
);

    logic [DATA_W-1:0] slice [NUM_PAGES];

    for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_slice
        assign slice[gi] = data_out_page[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_PAGES; i++) begin
            if (page_idx == PAGE_IDX_W'(i)) begin
                rd_data = slice[i];
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store access controller for the paged data memory: one request at a time,
// setup/strobe/hold write sequencing, timed read sampling and error responses.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_PAGES = 4,
    parameter int READ_LAT  = 1
) (
    input  logic                          CLK_MEMCTRL,
    input  logic                          RST_N_MEMCTRL,
    input  logic                          REQ_VALID,
    output logic                          REQ_READY,
    input  logic                          REQ_WE,
    input  logic [15:0]                   REQ_ADDR,
    input  logic [DATA_W-1:0]             REQ_WDATA,
    output logic                          RSP_VALID,
    input  logic                          RSP_READY,
    output logic [DATA_W-1:0]             RSP_RDATA,
    output logic                          RSP_ERR,
    output logic [PAGE_ADDR_W-1:0]        ADDR_PAGE,
    output logic [DATA_W-1:0]             DATA_IN_PAGE,
    output logic [NUM_PAGES-1:0]          PAGE_SEL,
    output logic                          WR_STB_PAGE,
    input  logic [DATA_W*NUM_PAGES-1:0]   DATA_OUT_PAGE
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t                  state_reg;
    logic                    we_reg;
    logic [PAGE_IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [DATA_W-1:0]       mux_rdata;
    logic [PAGE_IDX_W-1:0]   req_idx;

    assign req_idx = REQ_ADDR[15:12];

    page_rd_mux #(
        .NUM_PAGES (NUM_PAGES)
    ) u_page_rd_mux (
        .data_out_page (DATA_OUT_PAGE),
        .page_idx      (idx_reg),
        .rd_data       (mux_rdata)
    );

    always_ff @(posedge CLK_MEMCTRL) begin
        if (!RST_N_MEMCTRL) begin
            state_reg    <= ST_IDLE;
            we_reg       <= 1'b0;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            REQ_READY    <= 1'b1;
            RSP_VALID    <= 1'b0;
            RSP_RDATA    <= '0;
            RSP_ERR      <= 1'b0;
            ADDR_PAGE    <= '0;
            DATA_IN_PAGE <= '0;
            PAGE_SEL     <= '0;
            WR_STB_PAGE  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        REQ_READY <= 1'b0;
                        we_reg    <= REQ_WE;
                        idx_reg   <= req_idx;
                        // Out-of-range pages answer immediately and never touch the page bus.
                        if (!page_valid(req_idx, NUM_PAGES)) begin
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= 1'b1;
                            RSP_RDATA <= '0;
                            state_reg <= ST_RESP;
                        end else begin
                            ADDR_PAGE    <= REQ_ADDR[PAGE_ADDR_W-1:0];
                            DATA_IN_PAGE <= REQ_WDATA;
                            PAGE_SEL     <= NUM_PAGES'(1) << req_idx;
                            state_reg    <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (we_reg) begin
                        WR_STB_PAGE <= 1'b1;
                        state_reg   <= ST_STROBE;
                    end else begin
                        cnt_reg   <= CNT_W'(READ_LAT - 1);
                        state_reg <= ST_RDWAIT;
                    end
                end
                ST_STROBE: begin
                    WR_STB_PAGE <= 1'b0;
                    state_reg   <= ST_HOLD;
                end
                ST_HOLD: begin
                    PAGE_SEL  <= '0;
                    RSP_VALID <= 1'b1;
                    RSP_ERR   <= 1'b0;
                    RSP_RDATA <= '0;
                    state_reg <= ST_RESP;
                end
                ST_RDWAIT: begin
                    if (cnt_reg == '0) begin
                        PAGE_SEL  <= '0;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= 1'b0;
                        RSP_RDATA <= mux_rdata;
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        REQ_READY <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
